// File: rtl/uart_upg_loader.sv
// UART boot loader: 8N1 receiver, length-prefixed frame parser, 32-bit word writer with XOR checksum.
// A write strobe appears one cycle after the internal byte valid; there is no backpressure (bytes are never stalled).
module uart_upg_loader #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o,
  output logic              busy_o
);
  localparam int CPB  = CLK_FREQ_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [2:0] {P_LEN_LO, P_LEN_HI, P_DATA, P_CHECK, P_DONE} p_st_e;

  rx_st_e rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic byte_vld_q, byte_vld_d, frm_err_q, frm_err_d;

  p_st_e st_q, st_d;
  logic [7:0] len_lo_q, len_lo_d, csum_q, csum_d;
  logic [15:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d, adr_q, adr_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] dat_q, dat_d;
  logic wen_q, wen_d, done_q, done_d, err_q, err_d;
  logic [16:0] n_new;

  // Receiver: falling edge (not low level) starts a byte, so a line held low after a bad stop bit cannot retrigger.
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      default: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d      = '0;
          rx_st_d    = RX_IDLE;
          byte_vld_d = rx_s2_q;
          frm_err_d  = !rx_s2_q;
        end
      end
    endcase
  end

  // Parser; the word index is compared in 16 bits, so ADDR_W is expected to be at most 16.
  always_comb begin
    st_d     = st_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    csum_d   = csum_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wen_d    = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    n_new    = {1'b0, sh_q, len_lo_q};
    if (frm_err_q && st_q != P_DONE) err_d = 1'b1;
    if (byte_vld_q) begin
      case (st_q)
        P_LEN_LO: begin
          err_d    = 1'b0;
          csum_d   = '0;
          idx_d    = '0;
          bcnt_d   = '0;
          len_lo_d = sh_q;
          st_d     = P_LEN_HI;
        end
        P_LEN_HI: begin
          len_d = n_new[15:0];
          if (n_new == 17'd0) begin
            st_d = P_CHECK;
          end else if (n_new > MAX_N) begin
            err_d = 1'b1;
            st_d  = P_LEN_LO;
          end else begin
            st_d = P_DATA;
          end
        end
        P_DATA: begin
          csum_d = csum_q ^ sh_q;
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {sh_q, asm_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wen_d = 1'b1;
            adr_d = idx_q;
            dat_d = {sh_q, asm_q};
            idx_d = idx_q + ADDR_W'(1);
            if ({{(16-ADDR_W){1'b0}}, idx_q} == len_q - 16'd1) st_d = P_CHECK;
          end
        end
        P_CHECK: begin
          if (sh_q == csum_q) begin
            done_d = 1'b1;
            st_d   = P_DONE;
          end else begin
            err_d = 1'b1;
            st_d  = P_LEN_LO;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      st_q       <= P_LEN_LO;
      len_lo_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      st_q       <= st_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;
  assign busy_o     = (st_q != P_LEN_LO) && (st_q != P_DONE);
endmodule

// File: doc/uart_upg_loader.md
# uart_upg_loader

- Serial boot loader that drives the data-memory programming port (`upg_wen`/`upg_adr`/`upg_dat`/`upg_done`).
- Receives 8N1 UART bytes, parses a length-prefixed frame and assembles little-endian 32-bit words.
- Issues one single-cycle write per word at incrementing word addresses.
- Signals completion only after the trailing checksum matches; memory hands the port back to the CPU at that point.

## Interface
- `CLK_FREQ_HZ`, 10_000_000: upg clock frequency.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` (integer division, must be ≥ 4).
- `ADDR_W`, 14: word-address width.
- `upg_clk_i` in 1: single clock; all logic on rising edge.
- `upg_rst_i` in 1: asynchronous, active-high reset.
- `rx_i` in 1: UART serial input, idle high, asynchronous to `upg_clk_i`.
- `upg_wen_o` out 1: one-cycle write strobe.
- `upg_adr_o` out ADDR_W: word address of current/last write.
- `upg_dat_o` out 32: write data.
- `upg_done_o` out 1: load complete; sticky until reset.
- `err_o` out 1: framing, length or checksum error.
- `busy_o` out 1: a frame is in progress (state ≠ LEN_LO and ≠ DONE).

## Operation
- **RX front end**
  - `rx_i` passes through a 2-flop synchronizer.
  - A falling edge while the RX is idle starts the bit counter.
  - The start bit is rechecked at `CLKS_PER_BIT/2`. If it reads high, the start is treated as a glitch and the RX returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` from the start-bit centre, LSB first.
  - Stop bit sampled high: the byte is delivered with a 1-cycle internal valid.
  - Stop bit sampled low: framing error. The byte is dropped and `err_o` is set.
- **Frame format**: `LEN_LO`, `LEN_HI` (16-bit word count N), then 4·N data bytes (LS byte first per word), then one checksum byte equal to the XOR of all data bytes.
- **FSM states** `LEN_LO → LEN_HI → DATA → CHECK → DONE`:
  - LEN_LO:
    - Accepting a byte clears `err_o`, the checksum accumulator and the word index.
    - Goes to LEN_HI.
  - LEN_HI:
    - N = 0: go to CHECK.
    - N > 2^ADDR_W: set `err_o`, return to LEN_LO.
    - Otherwise: go to DATA.
  - DATA:
    - Bytes shift into a 32-bit assembler; a 2-bit byte counter tracks position.
    - On the 4th byte: register `upg_dat_o` and `upg_adr_o` = word index, pulse `upg_wen_o`, then increment the index.
    - After word N−1, go to CHECK.
  - CHECK:
    - Match: go to DONE and set `upg_done_o`.
    - Mismatch: set `err_o` and return to LEN_LO (host retries; previously written words may be overwritten).
  - DONE: all further RX bytes are ignored until reset.
- `upg_adr_o` and `upg_dat_o` hold their last written values between writes.
- Framing-dropped bytes do not advance the parser or the checksum.

## Timing
- **Reset values**: all outputs 0, FSM in LEN_LO, RX idle, accumulators 0.
- **Reset mid-frame** aborts immediately. No partial write is issued.
- **Byte latency**:
  - Internal byte valid is asserted the cycle after the stop-bit sample edge.
  - `upg_wen_o` is high exactly one cycle, on the cycle after that valid.
  - `upg_adr_o` and `upg_dat_o` are stable in that same cycle.
- `upg_done_o` rises on the cycle after the checksum byte's valid.
- Back-to-back bytes (stop bit immediately followed by the next start bit) must be accepted with no loss.
- **Falling-edge detection**:
  - Re-arms from the stop-bit centre onward.
  - A start edge arriving during the second half of the stop bit is detected.

## Test plan
Test parameters: `CLK_FREQ_HZ`=1_152_000, `BAUD`=115200, giving 10 clocks/bit.

- **Reset**: assert `upg_rst_i` with `rx_i`=1 → all outputs 0. Deassert → still 0, `busy_o`=0.
- **Normal load**: send 02 00 78 56 34 12 EF BE AD DE 2A →
  - `upg_wen_o` pulses twice: adr 0/data 0x12345678, then adr 1/data 0xDEADBEEF.
  - `upg_done_o`=1 and `err_o`=0.
  - Then send 55 → no further writes.
- **Bad checksum, then retry**: same frame with checksum 00 → two writes, `err_o`=1, `upg_done_o`=0. Resend the correct frame → `err_o` clears at the first byte, `upg_done_o`=1.
- **Framing error / glitch**:
  - A 3-clock low glitch on idle `rx_i` → no byte, no error.
  - A byte with stop bit 0 sent between data bytes → `err_o`=1, byte ignored. The remaining correct bytes still produce the expected words.
- **Empty and oversize length**:
  - Frame 00 00 00 → `upg_done_o`=1 with zero writes.
  - Frame 01 40 (N=0x4001) → `err_o`=1, FSM back in LEN_LO.
- **Reset mid-data**: after 02 00 78 56, pulse reset → outputs 0, no write. A full valid frame afterwards loads adr 0 correctly.
